// File: rtl/config_frame_writer_if.sv
// Word-stream input and frame-latch output bundle of the configuration frame writer.
// The writer uses the slave modport; the bitstream/latch side uses master.
interface config_frame_writer_if #(
    parameter int WORDS_PER_FRAME = 4,
    parameter int NUM_COLUMNS     = 16,
    parameter int MAX_FRAMES      = 20
);
    logic [31:0]                    in_data;
    logic                           in_valid;
    logic                           in_ready;
    logic [32*WORDS_PER_FRAME-1:0]  FrameData;
    logic [NUM_COLUMNS-1:0]         ColumnSelect;
    logic [MAX_FRAMES-1:0]          FrameStrobe;
    logic                           busy;
    logic                           frame_done;
    logic                           err;

    modport slave (
        input  in_data, in_valid,
        output in_ready, FrameData, ColumnSelect, FrameStrobe, busy, frame_done, err
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, FrameData, ColumnSelect, FrameStrobe, busy, frame_done, err
    );
endinterface

// File: rtl/config_frame_writer.sv
// Assembles a header + data-word frame and strobes the addressed config latches
// with setup/hold margins so FrameData is never changing while a latch is open.
module config_frame_writer #(
    parameter int WORDS_PER_FRAME = 4,
    parameter int NUM_COLUMNS     = 16,
    parameter int MAX_FRAMES      = 20,
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    config_frame_writer_if.slave  bus
);
    localparam int FW = 32 * WORDS_PER_FRAME;
    localparam int CW = 16;

    typedef enum logic [2:0] {S_HEADER, S_DATA, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t                 r_state, w_next;
    logic [CW-1:0]          r_cnt;
    logic [7:0]             r_col, r_frm;
    logic                   r_drop;
    logic [FW-1:0]          r_frame_data;
    logic [NUM_COLUMNS-1:0] r_col_sel;
    logic [MAX_FRAMES-1:0]  r_frm_stb;
    logic                   r_done, r_err;

    logic                   w_ready, w_accept, w_hdr_ok, w_last_word;
    logic [7:0]             w_col, w_frm;
    logic [FW+31:0]         w_cat;

    assign w_col       = bus.in_data[31:24];
    assign w_frm       = bus.in_data[23:16];
    assign w_hdr_ok    = (32'(w_col) < 32'(NUM_COLUMNS)) && (32'(w_frm) < 32'(MAX_FRAMES));
    assign w_ready     = (r_state == S_HEADER) || (r_state == S_DATA);
    assign w_accept    = w_ready && bus.in_valid;
    assign w_last_word = (r_cnt == CW'(WORDS_PER_FRAME - 1));
    assign w_cat       = {r_frame_data, bus.in_data};

    assign bus.in_ready     = w_ready;
    assign bus.busy         = (r_state != S_HEADER);
    assign bus.FrameData    = r_frame_data;
    assign bus.ColumnSelect = r_col_sel;
    assign bus.FrameStrobe  = r_frm_stb;
    assign bus.frame_done   = r_done;
    assign bus.err          = r_err;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= S_HEADER;
        else       r_state <= w_next;
    end

    // SETUP lasts SETUP_CYCLES+1 cycles: its first cycle is the one in which the
    // last data word lands on FrameData, so the margin counts only stable cycles.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HEADER: if (w_accept) w_next = S_DATA;
            S_DATA:   if (w_accept && w_last_word) w_next = S_SETUP;
            S_SETUP:  if (r_cnt == CW'(SETUP_CYCLES)) w_next = r_drop ? S_HOLD : S_STROBE;
            S_STROBE: if (r_cnt == CW'(STROBE_CYCLES - 1)) w_next = S_HOLD;
            S_HOLD:   w_next = S_HEADER;
            default:  w_next = S_HEADER;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt        <= '0;
            r_col        <= '0;
            r_frm        <= '0;
            r_drop       <= 1'b0;
            r_frame_data <= '0;
            r_col_sel    <= '0;
            r_frm_stb    <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_next != r_state)
                r_cnt <= '0;
            else if ((r_state == S_DATA && w_accept) || r_state == S_SETUP || r_state == S_STROBE)
                r_cnt <= r_cnt + CW'(1);

            if (r_state == S_HEADER && w_accept) begin
                r_col  <= w_col;
                r_frm  <= w_frm;
                r_drop <= !w_hdr_ok;
                r_err  <= r_err | !w_hdr_ok;
            end

            if (r_state == S_DATA && w_accept)
                r_frame_data <= w_cat[FW-1:0];

            // Strobes are registered from the next state so they are high exactly while in STROBE.
            r_col_sel <= (w_next == S_STROBE) ? (NUM_COLUMNS'(1) << r_col) : '0;
            r_frm_stb <= (w_next == S_STROBE) ? (MAX_FRAMES'(1) << r_frm) : '0;
            r_done    <= (r_state == S_HOLD);
        end
    end
endmodule

// File: doc/config_frame_writer.md
Name: config_frame_writer

Overview:
- Write side of the fabric configuration path: builds one configuration frame from a 32-bit word stream and drives the level-sensitive config latches (D/E, transparent while E=1).
- Each frame is a header word followed by WORDS_PER_FRAME data words.
- Presents FrameData, then pulses the selected column/frame strobe with setup and hold margins so no latch ever samples changing data.
- Sits between the bitstream source (config port/UART/SPI front end) and the fabric's frame data/strobe distribution.

Parameters:
- WORDS_PER_FRAME, 4, 32-bit data words per frame; FRAME_WIDTH = 32*WORDS_PER_FRAME.
- NUM_COLUMNS, 16, fabric columns; one select line per column.
- MAX_FRAMES, 20, frames per column; one strobe line per frame.
- SETUP_CYCLES, 1, cycles (>=1) FrameData is stable before the strobe rises.
- STROBE_CYCLES, 2, cycles (>=1) the strobe is held high.

Ports:
- CLK  in  1  configuration clock
- RESET  in  1  asynchronous, active-high reset
- in_data  in  32  header or data word
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid & in_ready at CLK rise
- FrameData  out  FRAME_WIDTH  frame data bus to all latches
- ColumnSelect  out  NUM_COLUMNS  one-hot column select
- FrameStrobe  out  MAX_FRAMES  one-hot frame strobe (latch E = ColumnSelect[c] & FrameStrobe[f])
- busy  out  1  high outside HEADER state
- frame_done  out  1  one-cycle pulse after a frame completes (written or dropped)
- err  out  1  sticky: header addressed a nonexistent column/frame

Behaviour:
- Reset (async): state=HEADER, FrameData=0, ColumnSelect=0, FrameStrobe=0, frame_done=0, err=0, word count=0. All outputs except in_ready/busy are registered. in_ready/busy decode state combinationally.
- Header word fields: col=in_data[31:24], frm=in_data[23:16]. [15:0] is ignored.
- Header is valid iff col<NUM_COLUMNS and frm<MAX_FRAMES. An invalid header sets err (sticky until RESET) and marks the frame as dropped.
- States:
  - HEADER: in_ready=1. On accept: latch col/frm/drop, clear word count, go to DATA.
  - DATA: in_ready=1. Each accept shifts left: FrameData <= {FrameData[FRAME_WIDTH-33:0], in_data}, so the first data word ends in the MSBs. When the WORDS_PER_FRAME-th word is accepted, go to SETUP. in_valid low stalls without timeout.
  - SETUP: in_ready=0. Hold SETUP_CYCLES cycles, strobes low. If not dropped: go to STROBE. If dropped: go to HOLD.
  - STROBE: ColumnSelect=1<<col and FrameStrobe=1<<frm for exactly STROBE_CYCLES cycles, then both return to 0. Go to HOLD.
  - HOLD: 1 cycle, strobes 0, FrameData unchanged. frame_done=1 next cycle. Go to HEADER.
- Latency: last data word accepted at edge N → strobe high on cycles N+1+SETUP_CYCLES .. N+SETUP_CYCLES+STROBE_CYCLES → frame_done high at cycle N+SETUP_CYCLES+STROBE_CYCLES+2 (HEADER state, in_ready=1 that cycle).
- Invariants:
  - FrameData never changes while any strobe is high, nor in the cycle before a strobe rises or after it falls.
  - At most one ColumnSelect bit and one FrameStrobe bit are ever high.
  - Strobes are never high outside STROBE.
- FrameData keeps the last frame after completion. It is overwritten only by new DATA accepts.
- in_valid with in_ready=0 is ignored. The source must hold the word.
- RESET mid-frame (any state): strobes drop to 0 immediately (async). The partial frame is discarded and nothing is written.
- Dropped frames consume their data words, never raise strobes, and still pulse frame_done.

Test Plan:
- Basic write: header 0x0305_0000, data 0x11111111, 0x22222222, 0x33333333, 0x44444444, in_valid continuous → FrameData=0x11111111_22222222_33333333_44444444. ColumnSelect=0x0008 and FrameStrobe=1<<5 high exactly 2 cycles, starting 2 cycles after the last accept. frame_done at +5. err=0.
- Back-to-back: two frames with col 0/frm 0 and col 15/frm 19, no gaps → each strobe fires once. FrameData is stable from SETUP through HOLD of each frame. The second header is accepted the cycle frame_done pulses.
- Stalls: in_valid toggles 1/0 every cycle during DATA → same FrameData and strobe timing, relative to the last accept.
- Invalid address: header 0x1000_0000 (col 16) → 4 data words consumed, no strobe bit ever high, frame_done pulses, err=1 and stays 1. The next valid frame writes normally.
- Reset mid-strobe: assert RESET in the first STROBE cycle → ColumnSelect/FrameStrobe go to 0 within the cycle, FrameData=0, state HEADER, in_ready=1 after release.
- Backpressure: in_valid held high during SETUP/STROBE/HOLD with a changing in_data → no word accepted and FrameData unchanged.
